pc_seq: RTL and testbench

Parametrised program-sequencing unit; successor to the single-bit-select PC of the stack machine core. Holds the program counter and computes the next fetch address from increment, absolute branch, PC-relative branch, call/return and halt/stall controls. An optional return-address stack supports subroutine calls. Sits between the decode/control block and the instruction ROM address port.

---
 rtl/pc_seq_pkg.sv | 12 +
 rtl/pc_seq_if.sv | 26 ++
 rtl/pc_ras.sv | 47 ++++
 rtl/pc_seq.sv | 126 ++++++++++++
 tb/tb_pc_seq.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the pc_seq program-sequencing unit.
package pc_seq_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } pc_state_t;

  localparam int unsigned PC_W_DEF      = 8;
  localparam int unsigned RAS_DEPTH_DEF = 4;

endpackage

// File: rtl/pc_seq_if.sv
// Control/fetch bundle between decode (master) and the sequencer (slave).
interface pc_seq_if #(
    parameter int unsigned PC_W = pc_seq_pkg::PC_W_DEF
);
    logic            stall;
    logic            halt_req;
    logic            br_en;
    logic            br_rel;
    logic            call;
    logic            ret;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc;
    logic            halted;
    logic            ras_ovf;
    logic            ras_unf;

    modport master (
        output stall, halt_req, br_en, br_rel, call, ret, target,
        input  pc, halted, ras_ovf, ras_unf
    );

    modport slave (
        input  stall, halt_req, br_en, br_rel, call, ret, target,
        output pc, halted, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_ras.sv
// Return-address LIFO: single-cycle push/pop, no bypass, pointer-only reset.
module pc_ras #(
    parameter int unsigned PC_W      = pc_seq_pkg::PC_W_DEF,
    parameter int unsigned RAS_DEPTH = pc_seq_pkg::RAS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic            full,
    output logic            empty
);
    localparam int unsigned AW = $clog2(RAS_DEPTH);

    logic [PC_W-1:0] mem_q [2**AW];
    logic [AW:0]     sp_q, sp_d, sp_m1;

    always_comb begin
        sp_m1 = sp_q - (AW+1)'(1);
        full  = (sp_q == (AW+1)'(RAS_DEPTH));
        empty = (sp_q == '0);
        dout  = mem_q[sp_m1[AW-1:0]];
        sp_d  = sp_q;
        if (push && !full) begin
            sp_d = sp_q + (AW+1)'(1);
        end else if (pop && !empty) begin
            sp_d = sp_m1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Contents are don't-care after reset, so storage is left unreset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[sp_q[AW-1:0]] <= din;
        end
    end
endmodule

// File: rtl/pc_seq.sv
// Program counter with branch/call/return/halt sequencing.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W       = PC_W_DEF,
    parameter int unsigned RAS_DEPTH  = RAS_DEPTH_DEF,
    parameter int unsigned START_ADDR = 0
) (
    input  logic       clk,
    input  logic       reset,
    pc_seq_if.slave    bus
);
    if (RAS_DEPTH < 2) begin : g_bad_depth
        $error("pc_seq: RAS_DEPTH must be at least 2");
    end

    pc_state_t       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc, pc_rel;

`ifdef PC_RAS_EN
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            ras_push, ras_pop;
    logic [PC_W-1:0] ras_dout;
    logic            ras_full, ras_empty;

    pc_ras #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_inc),
        .dout  (ras_dout),
        .full  (ras_full),
        .empty (ras_empty)
    );
`endif

    // Same-width add wraps modulo 2^PC_W, which equals adding the sign-extended offset.
    assign pc_inc = pc_q + PC_W'(1);
    assign pc_rel = pc_q + bus.target;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
`ifdef PC_RAS_EN
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
`endif
        case (state_q)
            RUN: begin
                if (bus.stall) begin
                    pc_d = pc_q;
                end else if (bus.halt_req) begin
                    state_d = HALT;
                end else if (bus.ret) begin
`ifdef PC_RAS_EN
                    if (ras_empty) begin
                        pc_d  = pc_inc;
                        unf_d = 1'b1;
                    end else begin
                        ras_pop = 1'b1;
                        pc_d    = ras_dout;
                    end
`else
                    pc_d = pc_inc;
`endif
                end else if (bus.call) begin
`ifdef PC_RAS_EN
                    if (ras_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        ras_push = 1'b1;
                    end
`endif
                    pc_d = bus.target;
                end else if (bus.br_en) begin
                    pc_d = bus.br_rel ? pc_rel : bus.target;
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= PC_W'(START_ADDR);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef PC_RAS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.ras_ovf = ovf_q;
    assign bus.ras_unf = unf_q;
`else
    assign bus.ras_ovf = 1'b0;
    assign bus.ras_unf = 1'b0;
`endif

    assign bus.pc     = pc_q;
    assign bus.halted = (state_q == HALT);
endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq (PC_W=8, RAS_DEPTH=4, START_ADDR=0); adapts to PC_RAS_EN.
module tb_pc_seq;
`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    typedef struct {
        logic       rs, st, hr, be, br, ca, re;
        logic [7:0] tg;
        logic [7:0] pc;
        logic       hl, ov, un;
    } step_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    step_t sb[$];

    pc_seq_if #(.PC_W(8)) bus();

    pc_seq #(
        .PC_W       (8),
        .RAS_DEPTH  (4),
        .START_ADDR (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic step_t mk(logic rs, logic st, logic hr, logic be, logic br,
                                 logic ca, logic re, logic [7:0] tg,
                                 logic [7:0] pc, logic hl, logic ov, logic un);
        step_t s;
        s.rs = rs; s.st = st; s.hr = hr; s.be = be; s.br = br; s.ca = ca; s.re = re;
        s.tg = tg; s.pc = pc; s.hl = hl; s.ov = ov; s.un = un;
        return s;
    endfunction

    task automatic drive(input step_t s);
        reset        = s.rs;
        bus.stall    = s.st;
        bus.halt_req = s.hr;
        bus.br_en    = s.be;
        bus.br_rel   = s.br;
        bus.call     = s.ca;
        bus.ret      = s.re;
        bus.target   = s.tg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(mk(1, 0,0,0,0,0,0, 8'h00, 8'h00, 0,0,0));
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step_t tbl[$];
        step_t got;
        tbl.push_back(mk(1, 0,0,1,0,1,0, 8'h80, 8'h00, 0,0,0));
        tbl.push_back(mk(1, 0,1,0,0,0,1, 8'h80, 8'h00, 0,0,0));
        tbl.push_back(mk(0, 0,0,0,0,0,0, 8'h00, 8'h01, 0,0,0));
        foreach (tbl[i]) begin
            sb.push_back(tbl[i]);
            drive(tbl[i]);
            tick();
            got = sb.pop_front();
            checks++;
            if (bus.pc !== got.pc || bus.halted !== got.hl || bus.ras_ovf !== got.ov || bus.ras_unf !== got.un) begin
                errors++;
                $display("FAIL reset[%0d]: got pc=%h halted=%b ovf=%b unf=%b, want pc=%h halted=%b ovf=%b unf=%b",
                         i, bus.pc, bus.halted, bus.ras_ovf, bus.ras_unf, got.pc, got.hl, got.ov, got.un);
            end
        end
    endtask

    task automatic test_wrap();
        step_t got;
        do_reset();
        for (int i = 0; i < 260; i++) begin
            sb.push_back(mk(0, 0,0,0,0,0,0, 8'h00, 8'(i + 1), 0,0,0));
            drive(sb[$]);
            tick();
            got = sb.pop_front();
            checks++;
            if (bus.pc !== got.pc || bus.halted !== got.hl) begin
                errors++;
                $display("FAIL wrap[%0d]: got pc=%h halted=%b, want pc=%h halted=%b",
                         i, bus.pc, bus.halted, got.pc, got.hl);
            end
        end
    endtask

    task automatic test_branch();
        step_t tbl[$];
        step_t got;
        do_reset();
        tbl.push_back(mk(0, 0,0,1,0,0,0, 8'h10, 8'h10, 0,0,0));
        tbl.push_back(mk(0, 0,0,1,1,0,0, 8'hFE, 8'h0E, 0,0,0));
        tbl.push_back(mk(0, 0,0,1,0,0,0, 8'h40, 8'h40, 0,0,0));
        tbl.push_back(mk(0, 0,0,1,1,0,0, 8'h05, 8'h45, 0,0,0));
        tbl.push_back(mk(0, 0,0,0,0,0,0, 8'hFF, 8'h46, 0,0,0));
        tbl.push_back(mk(0, 0,0,1,1,0,0, 8'hC0, 8'h06, 0,0,0));
        foreach (tbl[i]) begin
            sb.push_back(tbl[i]);
            drive(tbl[i]);
            tick();
            got = sb.pop_front();
            checks++;
            if (bus.pc !== got.pc || bus.halted !== got.hl || bus.ras_ovf !== got.ov || bus.ras_unf !== got.un) begin
                errors++;
                $display("FAIL branch[%0d]: got pc=%h halted=%b ovf=%b unf=%b, want pc=%h halted=%b ovf=%b unf=%b",
                         i, bus.pc, bus.halted, bus.ras_ovf, bus.ras_unf, got.pc, got.hl, got.ov, got.un);
            end
        end
    endtask

    task automatic test_calls();
        step_t tbl[$];
        step_t got;
        do_reset();
        tbl.push_back(mk(0, 0,0,1,0,0,0, 8'h05, 8'h05, 0,0,0));
        tbl.push_back(mk(0, 0,0,0,0,1,0, 8'h20, 8'h20, 0,0,0));
        tbl.push_back(mk(0, 0,0,0,0,0,0, 8'h00, 8'h21, 0,0,0));
        tbl.push_back(mk(0, 0,0,0,0,1,0, 8'h30, 8'h30, 0,0,0));
        tbl.push_back(mk(0, 0,0,0,0,0,1, 8'h00, RAS ? 8'h22 : 8'h31, 0,0,0));
        tbl.push_back(mk(0, 0,0,0,0,0,1, 8'h00, RAS ? 8'h06 : 8'h32, 0,0,0));
        tbl.push_back(mk(0, 0,0,1,1,1,0, 8'h50, 8'h50, 0,0,0));
        tbl.push_back(mk(0, 0,0,1,0,0,1, 8'h90, RAS ? 8'h07 : 8'h51, 0,0,0));
        foreach (tbl[i]) begin
            sb.push_back(tbl[i]);
            drive(tbl[i]);
            tick();
            got = sb.pop_front();
            checks++;
            if (bus.pc !== got.pc || bus.halted !== got.hl || bus.ras_ovf !== got.ov || bus.ras_unf !== got.un) begin
                errors++;
                $display("FAIL calls[%0d]: got pc=%h halted=%b ovf=%b unf=%b, want pc=%h halted=%b ovf=%b unf=%b",
                         i, bus.pc, bus.halted, bus.ras_ovf, bus.ras_unf, got.pc, got.hl, got.ov, got.un);
            end
        end
    endtask

    task automatic test_overflow();
        step_t tbl[$];
        step_t got;
        do_reset();
        tbl.push_back(mk(0, 0,0,0,0,1,0, 8'h10, 8'h10, 0,0,0));
        tbl.push_back(mk(0, 0,0,0,0,1,0, 8'h20, 8'h20, 0,0,0));
        tbl.push_back(mk(0, 0,0,0,0,1,0, 8'h30, 8'h30, 0,0,0));
        tbl.push_back(mk(0, 0,0,0,0,1,0, 8'h40, 8'h40, 0,0,0));
        tbl.push_back(mk(0, 0,0,0,0,1,0, 8'h50, 8'h50, 0,RAS,0));
        tbl.push_back(mk(0, 0,0,0,0,0,1, 8'h00, RAS ? 8'h31 : 8'h51, 0,RAS,0));
        tbl.push_back(mk(0, 0,0,0,0,0,1, 8'h00, RAS ? 8'h21 : 8'h52, 0,RAS,0));
        tbl.push_back(mk(0, 0,0,0,0,0,1, 8'h00, RAS ? 8'h11 : 8'h53, 0,RAS,0));
        tbl.push_back(mk(0, 0,0,0,0,0,1, 8'h00, RAS ? 8'h01 : 8'h54, 0,RAS,0));
        tbl.push_back(mk(0, 0,0,0,0,0,1, 8'h00, RAS ? 8'h02 : 8'h55, 0,RAS,RAS));
        tbl.push_back(mk(0, 0,0,0,0,0,0, 8'h00, RAS ? 8'h03 : 8'h56, 0,RAS,RAS));
        foreach (tbl[i]) begin
            sb.push_back(tbl[i]);
            drive(tbl[i]);
            tick();
            got = sb.pop_front();
            checks++;
            if (bus.pc !== got.pc || bus.halted !== got.hl || bus.ras_ovf !== got.ov || bus.ras_unf !== got.un) begin
                errors++;
                $display("FAIL overflow[%0d]: got pc=%h halted=%b ovf=%b unf=%b, want pc=%h halted=%b ovf=%b unf=%b",
                         i, bus.pc, bus.halted, bus.ras_ovf, bus.ras_unf, got.pc, got.hl, got.ov, got.un);
            end
        end
    endtask

    task automatic test_stall();
        step_t tbl[$];
        step_t got;
        do_reset();
        tbl.push_back(mk(0, 0,0,0,0,1,0, 8'h20, 8'h20, 0,0,0));
        tbl.push_back(mk(0, 1,0,0,0,0,1, 8'h00, 8'h20, 0,0,0));
        tbl.push_back(mk(0, 1,0,1,0,1,0, 8'h70, 8'h20, 0,0,0));
        tbl.push_back(mk(0, 1,1,0,0,0,0, 8'h00, 8'h20, 0,0,0));
        tbl.push_back(mk(0, 0,0,0,0,0,1, 8'h00, RAS ? 8'h01 : 8'h21, 0,0,0));
        tbl.push_back(mk(0, 0,0,0,0,1,0, 8'h60, 8'h60, 0,0,0));
        tbl.push_back(mk(0, 0,0,0,0,1,1, 8'h70, RAS ? 8'h02 : 8'h61, 0,0,0));
        foreach (tbl[i]) begin
            sb.push_back(tbl[i]);
            drive(tbl[i]);
            tick();
            got = sb.pop_front();
            checks++;
            if (bus.pc !== got.pc || bus.halted !== got.hl || bus.ras_ovf !== got.ov || bus.ras_unf !== got.un) begin
                errors++;
                $display("FAIL stall[%0d]: got pc=%h halted=%b ovf=%b unf=%b, want pc=%h halted=%b ovf=%b unf=%b",
                         i, bus.pc, bus.halted, bus.ras_ovf, bus.ras_unf, got.pc, got.hl, got.ov, got.un);
            end
        end
    endtask

    task automatic test_halt();
        step_t tbl[$];
        step_t got;
        do_reset();
        tbl.push_back(mk(0, 0,0,0,0,0,1, 8'h00, 8'h01, 0,0,RAS));
        tbl.push_back(mk(0, 0,0,1,0,0,0, 8'h10, 8'h10, 0,0,RAS));
        tbl.push_back(mk(0, 0,0,0,0,1,0, 8'h33, 8'h33, 0,0,RAS));
        tbl.push_back(mk(0, 0,1,0,0,0,0, 8'h00, 8'h33, 1,0,RAS));
        tbl.push_back(mk(0, 0,0,1,0,0,0, 8'h44, 8'h33, 1,0,RAS));
        tbl.push_back(mk(0, 0,0,0,0,1,0, 8'h55, 8'h33, 1,0,RAS));
        tbl.push_back(mk(0, 0,0,0,0,0,1, 8'h00, 8'h33, 1,0,RAS));
        tbl.push_back(mk(0, 0,1,1,1,0,0, 8'h02, 8'h33, 1,0,RAS));
        tbl.push_back(mk(1, 0,0,0,0,0,0, 8'h00, 8'h00, 0,0,0));
        tbl.push_back(mk(0, 0,0,0,0,0,1, 8'h00, 8'h01, 0,0,RAS));
        foreach (tbl[i]) begin
            sb.push_back(tbl[i]);
            drive(tbl[i]);
            tick();
            got = sb.pop_front();
            checks++;
            if (bus.pc !== got.pc || bus.halted !== got.hl || bus.ras_ovf !== got.ov || bus.ras_unf !== got.un) begin
                errors++;
                $display("FAIL halt[%0d]: got pc=%h halted=%b ovf=%b unf=%b, want pc=%h halted=%b ovf=%b unf=%b",
                         i, bus.pc, bus.halted, bus.ras_ovf, bus.ras_unf, got.pc, got.hl, got.ov, got.un);
            end
        end
    endtask

    initial begin
        drive(mk(1, 0,0,0,0,0,0, 8'h00, 8'h00, 0,0,0));
        tick();
        test_reset();
        test_wrap();
        test_branch();
        test_calls();
        test_overflow();
        test_stall();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
